tensor_result_streamer: RTL

//  Drain side of the 8x8 tensor-core datapath: snapshots a full DIMxDIM result matrix
//  in one cycle and streams it out one element per transfer over a valid/ready port.

---
 rtl/tensor_pkg.sv | 20 ++
 rtl/tc_index_counter.sv | 59 +++++
 rtl/tensor_result_streamer.sv | 118 +++++++++++
 3 files changed

// File: rtl/tensor_pkg.sv
// Shared definitions for the tensor-core datapath blocks.
//  TC_DIM / TC_DATA_WIDTH : default matrix dimension and element width
//  TC_IDX_W               : width of a row or column index
//  tc_word_t / tc_matrix_t: one element / one full result matrix
//  tc_strm_state_t        : drain-side streamer states
package tensor_pkg;

  localparam int unsigned TC_DIM        = 8;
  localparam int unsigned TC_DATA_WIDTH = 32;
  localparam int unsigned TC_IDX_W      = $clog2(TC_DIM);

  typedef logic [TC_DATA_WIDTH-1:0] tc_word_t;
  typedef tc_word_t tc_matrix_t [TC_DIM][TC_DIM];

  typedef enum logic {
    IDLE,
    STREAM
  } tc_strm_state_t;

endpackage

// File: rtl/tc_index_counter.sv
// 2-D row/column wrap counter walking a DIM x DIM matrix.
//  clk, rst        : clock, asynchronous active-high reset
//  i_clear         : force both indices to zero (wins over i_inc)
//  i_inc           : advance one element in the selected order
//  o_row, o_col    : current indices
//  o_last          : current index is [DIM-1][DIM-1]
// COL_MAJOR=0 walks columns fastest, COL_MAJOR=1 walks rows fastest.
module tc_index_counter
  import tensor_pkg::*;
#(
  parameter int unsigned DIM       = TC_DIM,
  parameter bit          COL_MAJOR = 1'b0,
  localparam int unsigned IDX_W    = $clog2(DIM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_row,
  output logic [IDX_W-1:0] o_col,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] IdxMax = IDX_W'(DIM - 1);

  logic [IDX_W-1:0] r_row;
  logic [IDX_W-1:0] r_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (!COL_MAJOR) begin
        if (r_col == IdxMax) begin
          r_col <= '0;
          r_row <= (r_row == IdxMax) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else begin
        if (r_row == IdxMax) begin
          r_row <= '0;
          r_col <= (r_col == IdxMax) ? '0 : r_col + 1'b1;
        end else begin
          r_row <= r_row + 1'b1;
        end
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == IdxMax) && (r_col == IdxMax);

endmodule

// File: rtl/tensor_result_streamer.sv
// Drain side of the tensor core: snapshots a DIM x DIM result matrix in one cycle and
// streams it out one element per valid/ready transfer.
//  clk, rst                     : clock, asynchronous active-high reset
//  result_matrix, capture_valid : frame offered by the core
//  capture_ready                : frame accepted this cycle when capture_valid is high
//  out_data/row/col/last        : current element, its indices, final-element flag
//  out_valid, out_ready         : output handshake
//  busy                         : a frame is held
//  frame_done                   : one-cycle pulse after the final element transferred
module tensor_result_streamer
  import tensor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TC_DATA_WIDTH,
  parameter int unsigned DIM        = TC_DIM,
  parameter bit          COL_MAJOR  = 1'b0,
  localparam int unsigned IDX_W     = $clog2(DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] result_matrix [DIM][DIM],
  input  logic                  capture_valid,
  output logic                  capture_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_row,
  output logic [IDX_W-1:0]      out_col,
  output logic                  out_last,
  output logic                  busy,
  output logic                  frame_done
);

  tc_strm_state_t        r_state;
  tc_strm_state_t        w_state_next;
  logic [DATA_WIDTH-1:0] r_snap [DIM][DIM];
  logic                  r_frame_done;
  logic                  w_capture;
  logic                  w_xfer;
  logic                  w_last;
  logic [IDX_W-1:0]      w_row;
  logic [IDX_W-1:0]      w_col;

  assign w_xfer    = out_valid & out_ready;
  assign w_capture = capture_valid & capture_ready;
  // Accepting during the final transfer lets the next frame follow with no bubble.
  assign capture_ready = !rst & ((r_state == IDLE) | (w_xfer & w_last));

  tc_index_counter #(
    .DIM       (DIM),
    .COL_MAJOR (COL_MAJOR)
  ) u_idx (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_capture),
    .i_inc   (w_xfer),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_capture) begin
          w_state_next = STREAM;
        end
      end
      STREAM: begin
        if (w_xfer && w_last) begin
          w_state_next = w_capture ? STREAM : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == STREAM);
    busy      = (r_state == STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DIM); i++) begin
        for (int j = 0; j < int'(DIM); j++) begin
          r_snap[i][j] <= '0;
        end
      end
    end else if (w_capture) begin
      r_snap <= result_matrix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_xfer & w_last;
    end
  end

  // Element select straight from the snapshot, so indices and data move together.
  assign out_data   = r_snap[w_row][w_col];
  assign out_row    = w_row;
  assign out_col    = w_col;
  assign out_last   = w_last;
  assign frame_done = r_frame_done;

endmodule
